// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 types and constants
package arc4_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_LEN,
      WT_LEN,
      WR_LEN,
      CHECK,
      RD_SI,
      WT_SI,
      CALC_J,
      RD_SJ,
      WT_SJ,
      WR_SI,
      WR_SJ,
      RD_PAD,
      WT_PAD,
      WR_PT,
      DONE
   } prga_state_t;

   localparam logic [7:0] LEN_ADDR = 8'd0;
   localparam int         S_SIZE   = 256;

endpackage

// File: rtl/prga_if.sv
// rtl/prga_if.sv - start handshake plus S/CT/PT RAM ports of the PRGA stage
interface prga_if;

   logic       en;
   logic       rdy;
   logic [7:0] s_addr;
   logic [7:0] s_rddata;
   logic [7:0] s_wrdata;
   logic       s_wren;
   logic [7:0] ct_addr;
   logic [7:0] ct_rddata;
   logic [7:0] pt_addr;
   logic [7:0] pt_wrdata;
   logic       pt_wren;

   modport master (
      input  en,
      output rdy,
      output s_addr,
      input  s_rddata,
      output s_wrdata,
      output s_wren,
      output ct_addr,
      input  ct_rddata,
      output pt_addr,
      output pt_wrdata,
      output pt_wren
   );

   modport slave (
      output en,
      input  rdy,
      input  s_addr,
      output s_rddata,
      input  s_wrdata,
      input  s_wren,
      input  ct_addr,
      output ct_rddata,
      input  pt_addr,
      input  pt_wrdata,
      input  pt_wren
   );

endinterface

// File: rtl/prga.sv
// rtl/prga.sv - ARC4 keystream stage: decrypts length-prefixed CT into PT, permuting S in place
module prga
   import arc4_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   prga_if.master bus
);

   prga_state_t state;
   logic        rdy_q;
   logic [7:0]  i;
   logic [7:0]  j;
   logic [8:0]  k;
   logic [7:0]  len;
   logic [7:0]  si;
   logic [7:0]  sj;
   logic [7:0]  pad;
   logic [7:0]  ct;

   assign bus.rdy = rdy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rdy_q <= 1'b1;
         i     <= 8'd0;
         j     <= 8'd0;
         k     <= 9'd1;
         len   <= 8'd0;
         si    <= 8'd0;
         sj    <= 8'd0;
         pad   <= 8'd0;
         ct    <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               // rdy rises one cycle after DONE, so a held en cannot restart early
               if (bus.en && rdy_q) begin
                  state <= RD_LEN;
                  rdy_q <= 1'b0;
                  i     <= 8'd0;
                  j     <= 8'd0;
                  k     <= 9'd1;
               end else begin
                  rdy_q <= 1'b1;
               end
            end
            RD_LEN: state <= WT_LEN;
            WT_LEN: begin
               len   <= bus.ct_rddata;
               state <= WR_LEN;
            end
            WR_LEN: state <= CHECK;
            CHECK: begin
               // 9-bit k lets L=255 terminate at k=256 instead of wrapping
               if (k > {1'b0, len}) begin
                  state <= DONE;
               end else begin
                  i     <= i + 8'd1;
                  state <= RD_SI;
               end
            end
            RD_SI: state <= WT_SI;
            WT_SI: begin
               si    <= bus.s_rddata;
               state <= CALC_J;
            end
            CALC_J: begin
               j     <= j + si;
               state <= RD_SJ;
            end
            RD_SJ: state <= WT_SJ;
            WT_SJ: begin
               sj    <= bus.s_rddata;
               state <= WR_SI;
            end
            WR_SI:  state <= WR_SJ;
            WR_SJ:  state <= RD_PAD;
            RD_PAD: state <= WT_PAD;
            WT_PAD: begin
               pad   <= bus.s_rddata;
               ct    <= bus.ct_rddata;
               state <= WR_PT;
            end
            WR_PT: begin
               k     <= k + 9'd1;
               state <= CHECK;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.s_addr    = 8'd0;
      bus.s_wrdata  = 8'd0;
      bus.s_wren    = 1'b0;
      bus.ct_addr   = 8'd0;
      bus.pt_addr   = 8'd0;
      bus.pt_wrdata = 8'd0;
      bus.pt_wren   = 1'b0;
      case (state)
         RD_LEN, WT_LEN: bus.ct_addr = LEN_ADDR;
         WR_LEN: begin
            bus.pt_addr   = LEN_ADDR;
            bus.pt_wrdata = len;
            bus.pt_wren   = 1'b1;
         end
         RD_SI, WT_SI: bus.s_addr = i;
         RD_SJ, WT_SJ: bus.s_addr = j;
         WR_SI: begin
            bus.s_addr   = i;
            bus.s_wrdata = sj;
            bus.s_wren   = 1'b1;
         end
         WR_SJ: begin
            bus.s_addr   = j;
            bus.s_wrdata = si;
            bus.s_wren   = 1'b1;
         end
         RD_PAD, WT_PAD: begin
            bus.s_addr  = si + sj;
            bus.ct_addr = k[7:0];
         end
         WR_PT: begin
            bus.pt_addr   = k[7:0];
            bus.pt_wrdata = pad ^ ct;
            bus.pt_wren   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_prga.sv
// tb/tb_prga.sv - scoreboard bench for prga against a software ARC4 model
module tb_prga;
   import arc4_pkg::*;

   logic clk;
   logic rst_n;

   prga_if bus ();

   prga dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] smem  [S_SIZE];
   logic [7:0] ctmem [S_SIZE];
   logic [7:0] ptmem [S_SIZE];
   logic [7:0] exp_s [S_SIZE];

   logic       ld_we;
   logic [7:0] ld_a;
   logic [7:0] ld_d;

   logic [16:0] exp_q [$];

   int n_checks;
   int n_fail;
   int ptw_cnt;
   int swr_cnt;
   int viol;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   // synchronous RAMs, one-cycle read latency, read-before-write
   always @(posedge clk) begin
      bus.s_rddata  <= smem[bus.s_addr];
      bus.ct_rddata <= ctmem[bus.ct_addr];
      if (bus.s_wren)
         smem[bus.s_addr] <= bus.s_wrdata;
      else if (ld_we)
         smem[ld_a] <= ld_d;
      if (bus.pt_wren)
         ptmem[bus.pt_addr] <= bus.pt_wrdata;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.pt_wren) begin
            logic [16:0] want;
            ptw_cnt++;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h10000;
            check_eq("pt_write", {15'd0, 1'b0, bus.pt_addr, bus.pt_wrdata}, {15'd0, want});
         end
         if (bus.s_wren)
            swr_cnt++;
         if (bus.rdy && (bus.s_wren || bus.pt_wren))
            viol++;
      end
   end

   task automatic load_s(input bit use_ksa);
      logic [7:0] s [S_SIZE];
      logic [7:0] key [3];
      logic [7:0] jj;
      logic [7:0] t;
      key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
      for (int n = 0; n < S_SIZE; n++) s[n] = n[7:0];
      if (use_ksa) begin
         jj = 8'd0;
         for (int n = 0; n < S_SIZE; n++) begin
            jj    = jj + s[n] + key[n % 3];
            t     = s[n];
            s[n]  = s[jj];
            s[jj] = t;
         end
      end
      for (int n = 0; n < S_SIZE; n++) begin
         @(negedge clk);
         ld_we = 1'b1;
         ld_a  = n[7:0];
         ld_d  = s[n];
      end
      @(negedge clk);
      ld_we = 1'b0;
   endtask

   // push the expected PT writes and the post-run S image
   task automatic model_run(input int len);
      logic [7:0] ms [S_SIZE];
      logic [7:0] mi, mj, t, pad;
      for (int n = 0; n < S_SIZE; n++) ms[n] = smem[n];
      mi = 8'd0;
      mj = 8'd0;
      exp_q.push_back({1'b0, 8'd0, len[7:0]});
      for (int kk = 1; kk <= len; kk++) begin
         mi     = mi + 8'd1;
         mj     = mj + ms[mi];
         t      = ms[mi];
         ms[mi] = ms[mj];
         ms[mj] = t;
         pad    = ms[ms[mi] + ms[mj]];
         exp_q.push_back({1'b0, kk[7:0], ctmem[kk] ^ pad});
      end
      for (int n = 0; n < S_SIZE; n++) exp_s[n] = ms[n];
   endtask

   task automatic run(input int len, input string tag);
      int cnt;
      int mism;
      model_run(len);
      swr_cnt = 0;
      @(negedge clk);
      bus.en = 1'b1;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      check_eq({tag, "_rdy_drop"}, {31'd0, bus.rdy}, 32'd0);
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!bus.rdy && cnt < 4000);
      check_eq({tag, "_cycles"}, cnt, 6 + 11 * len);
      check_eq({tag, "_s_writes"}, swr_cnt, 2 * len);
      check_eq({tag, "_queue_left"}, exp_q.size(), 0);
      @(negedge clk);
      mism = 0;
      for (int n = 0; n < S_SIZE; n++)
         if (smem[n] !== exp_s[n]) mism++;
      check_eq({tag, "_s_final"}, mism, 0);
   endtask

   task automatic load_ct_msg3();
      ctmem[0] = 8'd3;
      ctmem[1] = 8'h41;
      ctmem[2] = 8'h00;
      ctmem[3] = 8'h00;
   endtask

   initial begin
      int guard;
      int base;
      n_checks = 0;
      n_fail   = 0;
      ptw_cnt  = 0;
      swr_cnt  = 0;
      viol     = 0;
      ld_we    = 1'b0;
      ld_a     = 8'd0;
      ld_d     = 8'd0;
      bus.en   = 1'b0;
      for (int n = 0; n < S_SIZE; n++) begin
         smem[n]  = 8'd0;
         ctmem[n] = 8'd0;
         ptmem[n] = 8'd0;
      end
      rst_n = 1'b1;

      // 1: asynchronous reset mid-clock, then idle with en low
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_rdy", {31'd0, bus.rdy}, 32'd1);
      check_eq("rst_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
      check_eq("rst_addr", {8'd0, bus.s_addr, bus.ct_addr, bus.pt_addr}, 32'd0);
      check_eq("rst_wrdata", {16'd0, bus.s_wrdata, bus.pt_wrdata}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_eq("idle_pt_writes", ptw_cnt, 0);
      check_eq("idle_s_writes", swr_cnt, 0);
      check_eq("idle_rdy", {31'd0, bus.rdy}, 32'd1);

      // 2: identity S, three bytes
      load_s(1'b0);
      load_ct_msg3();
      run(3, "ident");
      check_eq("ident_s2", smem[2], 8'd3);
      check_eq("ident_s3", smem[3], 8'd5);
      check_eq("ident_s5", smem[5], 8'd2);
      check_eq("ident_pt", {ptmem[0], ptmem[1], ptmem[2], ptmem[3]}, 32'h03430507);

      // 3: empty message
      ctmem[0] = 8'd0;
      run(0, "len0");

      // 4: KSA-scheduled S, full-length message
      load_s(1'b1);
      ctmem[0] = 8'd255;
      for (int n = 1; n < S_SIZE; n++) ctmem[n] = 8'($urandom_range(0, 255));
      run(255, "len255");

      // 5: en pulsed while busy, then reset at byte 2
      load_s(1'b0);
      load_ct_msg3();
      model_run(3);
      base = ptw_cnt;
      @(negedge clk);
      bus.en = 1'b1;
      @(posedge clk);
      #1 bus.en = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.en = 1'b1;
      @(posedge clk);
      #1 bus.en = 1'b0;
      check_eq("busy_rdy", {31'd0, bus.rdy}, 32'd0);
      guard = 0;
      while (ptw_cnt < base + 2 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check_eq("byte2_reached", {31'd0, guard >= 500}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("abort_rdy", {31'd0, bus.rdy}, 32'd1);
      check_eq("abort_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      load_s(1'b0);
      load_ct_msg3();
      run(3, "rerun");
      check_eq("rerun_pt", {ptmem[0], ptmem[1], ptmem[2], ptmem[3]}, 32'h03430507);

      check_eq("wren_while_rdy", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
